pipe_trace_buffer: RTL
======================

Name: pipe_trace_buffer

Overview:
- Parametrised debug trace capture for the 16-bit MIPS pipeline; successor to the single-snapshot debug top.
- Every cycle it records NUM_CH probe words (e.g. ins, A, B, ans_ex) into a circular buffer.
- A selectable trigger freezes capture after a programmable number of post-trigger samples.
- The frozen buffer is then read out oldest-first through a pop interface.

Parameters:
- DATA_W, 16, width of one probe channel.
- NUM_CH, 4, number of probe channels captured per sample.
- DEPTH, 16, samples stored; power of two, >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- arm  input  1  one-cycle pulse; (re)starts a capture.
- trig_mode  input  2  0 force, 1 address match, 2 interrupt rising edge, 3 address match AND interrupt high.
- trig_force  input  1  manual trigger, used in mode 0.
- trig_addr  input  16  address compared with current_address.
- post_count  input  $clog2(DEPTH)  samples captured after the trigger sample.
- current_address  input  16  pipeline PC probe.
- interrupt  input  1  pipeline interrupt line.
- ch_data  input  NUM_CH*DATA_W  probe words; channel 0 occupies the LSBs.
- rd_req  input  1  pop the next sample (honoured in DONE only).
- rd_data  output  NUM_CH*DATA_W  popped sample.
- rd_valid  output  1  rd_data valid this cycle.
- state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count  output  $clog2(DEPTH+1)  samples held or remaining to read.
- trig_index  output  $clog2(DEPTH)  position of the trigger sample in readout order.
- triggered  output  1  high from trigger detection until the next arm or reset.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; count, trig_index, rd_data, triggered, rd_valid and all pointers = 0.
  - Buffer contents don't-care.
  - Reset asserted mid-operation aborts immediately: capture, readout and a pending rd_valid are all discarded.
- IDLE: no capture. arm -> ARMED.
- ARMED:
  - Writes ch_data at wr_ptr every cycle; wr_ptr increments mod DEPTH.
  - count saturates at DEPTH.
  - Trigger is evaluated combinationally against the current cycle's inputs.
  - On trigger, that cycle's sample is still written (it is the trigger sample) and triggered goes 1.
  - trig_index = count before the write, clamped to DEPTH-1-post_count, so the trigger sample is never overwritten.
  - If post_count==0 -> DONE, else -> POST with post_left=post_count.
- POST:
  - Writes each cycle and decrements post_left.
  - The write with post_left==1 is the last one -> DONE.
  - Further triggers are ignored.
- DONE:
  - Capture frozen.
  - rd_req with count>0: rd_data = oldest sample (rd_ptr = wr_ptr - count mod DEPTH); rd_valid is high the next cycle (1-cycle latency); count decrements.
  - rd_req with count==0: no rd_valid, no state change.
  - Back-to-back rd_req is allowed, giving one sample per cycle.
  - trig_index is relative to the first popped sample.
- arm priority:
  - arm in any state clears count, triggered, trig_index and post_left, then -> ARMED.
  - A trigger coincident with arm is ignored.
  - arm wins over rd_req in the same cycle; that pop does not happen.
- Trigger sources:
  - Mode 2 uses a registered interrupt_q, reset to 0. An interrupt already high at arm fires only after it falls and rises again.
  - Mode 1 is an exact 16-bit equality.
- post_count applies from the trigger cycle onward (it is sampled at the trigger).

Decomposition:
- Shared package holds:
  - state encoding constants (ST_IDLE/ST_ARMED/ST_POST/ST_DONE);
  - trig_mode constants (TRIG_FORCE/TRIG_ADDR/TRIG_IRQ_EDGE/TRIG_ADDR_IRQ).
- One sub-module, trace_ram: DEPTH x NUM_CH*DATA_W, single write port, registered read port. It gives the 1-cycle read latency and can map to block RAM.

Test Plan:
- Reset: hold reset=0 with random inputs -> state=0, count=0, rd_valid=0, triggered=0. Release, no arm for 20 cycles -> unchanged.
- Address trigger, no wrap:
  - Stimulus: ch_data = cycle index n from arm; mode 1, trig_addr=0x0020 presented at n=5; post_count=3.
  - Response: DONE after n=8, count=9, trig_index=5. Ten rd_req produce data 0..8 with rd_valid one cycle after each, count reaches 0, and the tenth pop gives no rd_valid.
- Wrap:
  - Stimulus: force trigger at n=40, post_count=7.
  - Response: count=16, trig_index=8, readout 32..47.
- Interrupt edge:
  - Stimulus: interrupt high before arm and held; then low at n=3, high at n=6; post_count=0.
  - Response: trigger at n=6, count=7, trig_index=6.
- Re-arm:
  - Stimulus: arm pulsed during POST.
  - Response: state=ARMED next cycle, count=0, triggered=0; a coincident trig_force is ignored.
- Reset mid-readout: assert reset after 2 pops -> rd_valid=0, state=IDLE, count=0 asynchronously.

Source files
------------

// File: rtl/pipe_trace_buffer_pkg.sv
// rtl/pipe_trace_buffer_pkg.sv - shared state and trigger-mode encodings for the trace buffer
package pipe_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TRIG_FORCE    = 2'd0;
  localparam logic [1:0] TRIG_ADDR     = 2'd1;
  localparam logic [1:0] TRIG_IRQ_EDGE = 2'd2;
  localparam logic [1:0] TRIG_ADDR_IRQ = 2'd3;

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// rtl/pipe_trace_buffer_trace_ram.sv - sample store with one write port and a registered read port
module trace_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register is reset so a popped word never survives an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular multi-channel pipeline trace capture with trigger and oldest-first readout
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = NUM_CH * DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic [1:0]    trig_mode,
  input  logic          trig_force,
  input  logic [15:0]   trig_addr,
  input  logic [AW-1:0] post_count,
  input  logic [15:0]   current_address,
  input  logic          interrupt,
  input  logic [SW-1:0] ch_data,
  input  logic          rd_req,
  output logic [SW-1:0] rd_data,
  output logic          rd_valid,
  output logic [1:0]    state,
  output logic [CW-1:0] count,
  output logic [AW-1:0] trig_index,
  output logic          triggered
);

  state_t        st, st_next;
  logic [AW-1:0] wr_ptr, post_left, trig_lim, trig_pos, rd_ptr;
  logic [CW-1:0] count_q, count_inc;
  logic          trig_q, irq_q, rd_valid_q;
  logic          trig_hit, capture, pop;

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_FORCE:    trig_hit = trig_force;
      TRIG_ADDR:     trig_hit = (current_address == trig_addr);
      TRIG_IRQ_EDGE: trig_hit = interrupt && !irq_q;
      TRIG_ADDR_IRQ: trig_hit = (current_address == trig_addr) && interrupt;
      default:       trig_hit = 1'b0;
    endcase
  end

  assign count_inc = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
  // Clamp keeps the trigger sample inside the window once post samples land.
  assign trig_lim  = AW'(DEPTH - 1) - post_count;
  assign trig_pos  = (count_q > CW'(trig_lim)) ? trig_lim : count_q[AW-1:0];
  assign rd_ptr    = wr_ptr - count_q[AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= ST_IDLE;
    else        st <= st_next;
  end

  always_comb begin
    st_next = st;
    capture = 1'b0;
    pop     = 1'b0;
    if (arm) begin
      st_next = ST_ARMED;
    end else begin
      case (st)
        ST_ARMED: begin
          capture = 1'b1;
          if (trig_hit) st_next = (post_count == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: begin
          capture = 1'b1;
          if (post_left == AW'(1)) st_next = ST_DONE;
        end
        ST_DONE: pop = rd_req && (count_q != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      post_left  <= '0;
      count_q    <= '0;
      trig_index <= '0;
      trig_q     <= 1'b0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      irq_q      <= interrupt;
      rd_valid_q <= pop;
      if (arm) begin
        count_q    <= '0;
        trig_q     <= 1'b0;
        trig_index <= '0;
        post_left  <= '0;
      end else begin
        if (capture) begin
          wr_ptr  <= wr_ptr + AW'(1);
          count_q <= count_inc;
        end
        if (st == ST_ARMED && trig_hit) begin
          trig_q     <= 1'b1;
          trig_index <= trig_pos;
          post_left  <= post_count;
        end
        if (st == ST_POST) post_left <= post_left - AW'(1);
        if (pop) count_q <= count_q - CW'(1);
      end
    end
  end

  trace_ram #(.WIDTH(SW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_addr (wr_ptr),
    .wr_data (ch_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign state     = st;
  assign count     = count_q;
  assign triggered = trig_q;
  assign rd_valid  = rd_valid_q;

endmodule
